mem_stage_ctrl: RTL

//  Memory-stage controller between the E/M and M/W pipeline registers.

---
 rtl/mem_stage_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: one request per load/store to a multi-cycle memory, pipeline stalled until memDone.
// Build define MEM_TIMEOUT_EN adds a BUSY watchdog that flags an error and forces completion after TIMEOUT_CYCLES.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        memRdM,
  input  logic        memWrtM,
  input  logic [15:0] aluFinalM,
  input  logic [15:0] wrDataM,
  input  logic        regWrtM,
  input  logic [15:0] memDataIn,
  input  logic        memDone,
  output logic        memEn,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWrData,
  output logic [15:0] memOutM,
  output logic        regWrtOutM,
  output logic        stallM,
  output logic        errM
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie within 2..32 to fit the 5-bit watchdog");
  end

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_memAddr;
  logic [15:0] r_memWrData;
  logic [15:0] r_memOut;
  logic        r_memWr;
  logic        w_access;
  logic        w_bad;
  logic        w_req;
  logic        w_stall;
  logic        w_err;
  logic        w_timeout;

  assign w_access = validM & (memRdM | memWrtM);
  assign w_bad    = w_access & (aluFinalM[0] | (memRdM & memWrtM));

`ifdef MEM_TIMEOUT_EN
  logic [4:0] r_wdog;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a memDone in that same cycle still wins.
  assign w_timeout = (r_state == S_BUSY) && !memDone &&
                     (r_wdog == 5'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_BUSY && w_next == S_BUSY) begin
      r_wdog <= r_wdog + 5'd1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_bad) begin
          w_err = 1'b1;
        end else if (w_access) begin
          w_req   = 1'b1;
          w_stall = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (memDone) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_err  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memAddr   <= '0;
      r_memWrData <= '0;
      r_memWr     <= 1'b0;
    end else if (w_req) begin
      r_memAddr   <= aluFinalM;
      r_memWrData <= wrDataM;
      r_memWr     <= memWrtM;
    end
  end

  // r_memWr doubles as the load/store tag of the in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memOut <= '0;
    end else if (r_state == S_BUSY && memDone && !r_memWr) begin
      r_memOut <= memDataIn;
    end else if (w_timeout) begin
      r_memOut <= 16'h0000;
    end
  end

  assign memEn      = w_req;
  assign memWr      = w_req ? memWrtM : r_memWr;
  assign memAddr    = r_memAddr;
  assign memWrData  = r_memWrData;
  assign memOutM    = r_memOut;
  assign stallM     = w_stall;
  assign errM       = w_err;
  assign regWrtOutM = regWrtM & ~w_stall & ~w_err;

endmodule
